// File: rtl/uart_tx_ctrl.sv
//------------------------------------------------------------------------------
// uart_tx_ctrl : UART transmit sequencer (start, LSB-first data, parity, stop)
// Revision     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_ctrl #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    input  logic            parity_en,
    input  logic            parity_odd,
    input  logic            stop2,
    output logic            tx,
    output logic            busy,
    output logic            tx_done_tick
);

    localparam int SW = $clog2(2 * SB_TICK);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_PARITY = 3'd3;
    localparam logic [2:0] c_S_STOP   = 3'd4;

    localparam logic [SW-1:0] c_BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] c_STOP1_LIM = SW'(SB_TICK - 1);
    localparam logic [SW-1:0] c_STOP2_LIM = SW'(2 * SB_TICK - 1);
    localparam logic [NW-1:0] c_N_LAST    = NW'(DBIT - 1);

    logic [2:0]      r_state, w_state_nxt;
    logic [SW-1:0]   r_s, w_s_nxt;
    logic [NW-1:0]   r_n, w_n_nxt;
    logic [DBIT-1:0] r_b, w_b_nxt;
    logic            r_pe, w_pe_nxt;
    logic            r_s2, w_s2_nxt;
    logic            r_par, w_par_nxt;
    logic            r_tx, w_tx_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic [SW-1:0]   w_stop_lim;

    assign w_stop_lim = r_s2 ? c_STOP2_LIM : c_STOP1_LIM;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_pe    <= 1'b0;
            r_s2    <= 1'b0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
            r_pe    <= w_pe_nxt;
            r_s2    <= w_s2_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_pe_nxt    = r_pe;
        w_s2_nxt    = r_s2;
        w_par_nxt   = r_par;
        case (r_state)
            c_S_IDLE: begin
                // A tick coinciding with acceptance is dropped: START begins at s=0.
                if (tx_start) begin
                    w_b_nxt     = din;
                    w_pe_nxt    = parity_en;
                    w_s2_nxt    = stop2;
                    w_par_nxt   = (^din) ^ parity_odd;
                    w_s_nxt     = '0;
                    w_state_nxt = c_S_START;
                end
            end
            c_S_START: begin
                if (s_tick) begin
                    if (r_s == c_BIT_LAST) begin
                        w_s_nxt     = '0;
                        w_n_nxt     = '0;
                        w_state_nxt = c_S_DATA;
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            c_S_DATA: begin
                if (s_tick) begin
                    if (r_s == c_BIT_LAST) begin
                        w_s_nxt = '0;
                        w_b_nxt = r_b >> 1;
                        if (r_n == c_N_LAST) begin
                            w_state_nxt = r_pe ? c_S_PARITY : c_S_STOP;
                        end else begin
                            w_n_nxt = r_n + 1'b1;
                        end
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            c_S_PARITY: begin
                if (s_tick) begin
                    if (r_s == c_BIT_LAST) begin
                        w_s_nxt     = '0;
                        w_state_nxt = c_S_STOP;
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            c_S_STOP: begin
                if (s_tick) begin
                    if (r_s == w_stop_lim) begin
                        w_s_nxt     = '0;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_s_nxt = r_s + 1'b1;
                    end
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered pins line up with it.
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = (w_state_nxt != c_S_IDLE);
        w_done_nxt = (r_state == c_S_STOP) && s_tick && (r_s == w_stop_lim);
        case (w_state_nxt)
            c_S_START:  w_tx_nxt = 1'b0;
            c_S_DATA:   w_tx_nxt = w_b_nxt[0];
            c_S_PARITY: w_tx_nxt = r_par;
            default:    w_tx_nxt = 1'b1;
        endcase
    end

    assign tx           = r_tx;
    assign busy         = r_busy;
    assign tx_done_tick = r_done;

endmodule

`default_nettype wire

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller. It sequences one serial frame (start, data LSB-first, optional parity, 1 or 2 stop bits) from the 16x-oversampled tick produced by the baud_rate counter (its done output feeds s_tick). It sits between the host-side byte interface and the tx pin. It is the sequencing consumer of the shared baud tick.

Parameters:
DBIT, 8, number of data bits per frame (5..9)
SB_TICK, 16, s_tick count per stop bit; also the tick count for start, data and parity bits (fixed at 16)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
s_tick  input  1  one-cycle oversample tick from baud_rate done, 16 per bit period
tx_start  input  1  request to send din; sampled only in IDLE
din  input  DBIT  data word to transmit
parity_en  input  1  1 = insert parity bit after data
parity_odd  input  1  0 = even parity, 1 = odd parity
stop2  input  1  1 = two stop bits
tx  output  1  serial line, registered, idle high
busy  output  1  high while a frame is in progress (state != IDLE)
tx_done_tick  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (synchronous, sampled on posedge clk): state=IDLE, tx=1, busy=0, tx_done_tick=0, tick counter s=0, bit counter n=0, shift register b=0. Reset mid-frame aborts the frame; tx=1 on the next cycle; no tx_done_tick is generated.
- All outputs are registered, so tx is glitch-free.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1; s_tick is ignored.
  - On tx_start=1: latch din into b. Latch parity_en, parity_odd and stop2. Latch par = (XOR of din) XOR parity_odd. Set s=0 and go to START.
  - tx=0 and busy=1 from the next cycle (1-cycle latency).
- START:
  - tx=0.
  - On s_tick with s==15: s=0, n=0, go to DATA.
  - On any other s_tick: s=s+1.
- DATA:
  - tx=b[0].
  - On s_tick with s==15: s=0, shift b right by 1.
  - If n==DBIT-1, go to PARITY when parity_en latched=1, else STOP. Otherwise n=n+1.
- PARITY:
  - tx=par.
  - On s_tick with s==15: s=0, go to STOP.
- STOP:
  - tx=1.
  - Limit L = SB_TICK-1, or 2*SB_TICK-1 when stop2 latched=1.
  - On s_tick with s==L: go to IDLE and assert tx_done_tick for exactly one cycle (the first cycle back in IDLE, busy=0).
  - s is sized ceil(log2(2*SB_TICK)) bits (5 for default); n is sized ceil(log2(DBIT)) bits.
- Timing is counted only in s_tick events, not clk cycles. Cycles without s_tick hold all state and tx.
- tx_start while busy=1 is ignored; it is not queued. tx_start in the same cycle as tx_done_tick=1 is accepted, giving back-to-back frames.
- din and the config inputs may change after acceptance without affecting the current frame.
- Frame length in ticks = 16*(1+DBIT+parity_en) + SB_TICK*(1+stop2).
- Simultaneous s_tick and tx_start in IDLE: the tick is ignored; s starts at 0 in START.

Test Plan:
- DBIT=8, din=0x55, parity_en=0, stop2=0, s_tick every 4 clk -> tx holds 0,1,0,1,0,1,0,1,0,1 for 16 ticks each. tx_done_tick pulses once after 160 ticks. busy is high across exactly the frame.
- din=0x07, parity_en=1, parity_odd=0 -> parity bit 1. Repeat with parity_odd=1 -> parity bit 0. Frame is 176 ticks.
- stop2=1, din=0xA3, parity_en=0 -> tx high for 32 ticks after data. tx_done_tick after 176 ticks.
- tx_start pulsed at tick 40 of a frame with din=0xFF -> ignored: the frame carries the original byte, and no second frame follows. Next, tx_start in the tx_done_tick cycle -> second frame's start bit begins the next cycle.
- reset asserted in DATA state -> next cycle tx=1, busy=0, tx_done_tick stays 0. Then tx_start din=0x3C -> full correct frame.
- Irregular s_tick gaps (1-20 clk random) -> bit boundaries fall on every 16th tick exactly. tx is stable between ticks.
